// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 slave receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } spi_rx_state_t;

  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// One-bit synchroniser with rise/fall pulses taken from the last stage.
// STAGES must be at least 2. RST_VAL sets the level that every stage
// and the edge-detect copy hold during reset.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              q_d;

  // Shift the asynchronous input through the synchroniser chain and keep a delayed copy for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      q_d    <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
      q_d    <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave receiver.
// Oversamples sclk/cs/mosi in the clk domain, deserialises one D_WIDTH word
// per cs-low frame and reports it with a one-clk d_valid pulse.
// Optional feature macro: SPI_SLAVE_MISO_EN returns tx_data on miso.
//
// state   | meaning
// IDLE    | waiting for cs fall; sclk activity ignored
// SHIFT   | frame in progress, sampling mosi on each sclk rise
// WAIT_CS | word delivered, waiting for cs rise; extra sclk rises flag an error
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int D_WIDTH     = 16,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sclk,
  input  logic               cs,
  input  logic               mosi,
  output logic               miso,
  input  logic [D_WIDTH-1:0] tx_data,
  output logic [D_WIDTH-1:0] d_out,
  output logic               d_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int             CW       = $clog2(D_WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(D_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(D_WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  spi_rx_state_t      state, state_nxt;
  logic [CW-1:0]      bit_cnt;
  logic [D_WIDTH-1:0] shift_reg;
  logic               err_done;

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  logic frame_start, shift_en, load_out, valid_nxt, err_nxt, err_set;

  // cs resets to the asserted level so a cs already low at reset release produces no fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d_in(sclk),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d_in(cs),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d_in(mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    load_out    = 1'b0;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == CNT_FULL) begin
          // A cs rise that coincided with the final sclk rise is already visible as cs_s high.
          load_out  = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = cs_s ? IDLE : WAIT_CS;
        end else if (cs_rise && !(sclk_rise && bit_cnt == CNT_LAST)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      WAIT_CS: begin
        if (sclk_rise && !err_done) begin
          err_nxt = 1'b1;
          err_set = 1'b1;
        end
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Receive shift register, saturating bit counter, output word and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      err_done  <= 1'b0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      d_valid   <= valid_nxt;
      frame_err <= err_nxt;
      if (frame_start) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
        err_done  <= 1'b0;
      end else begin
        if (shift_en) begin
          shift_reg <= {shift_reg[D_WIDTH-2:0], mosi_s};
          if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + CNT_ONE;
        end
        if (err_set) err_done <= 1'b1;
      end
      if (load_out) d_out <= shift_reg;
    end
  end

  assign busy = (state != IDLE);

`ifdef SPI_SLAVE_MISO_EN
  logic [D_WIDTH-1:0] tx_shift;

  // Transmit word is captured at frame start and advanced on each sclk fall so the master sees it on the next rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift <= '0;
    end else if (state == IDLE && cs_fall) begin
      tx_shift <= tx_data;
    end else if (state == SHIFT && sclk_fall) begin
      tx_shift <= {tx_shift[D_WIDTH-2:0], 1'b0};
    end
  end

  assign miso = (state == IDLE) ? 1'b0 : tx_shift[D_WIDTH-1];
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, sclk_fall};
  assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx (D_WIDTH=16).
// A scoreboard queue holds expected d_valid/frame_err events; a monitor
// pops and compares whenever the DUT pulses either output.
module tb_spi_slave_rx;

  localparam int D_WIDTH = 16;

`ifdef SPI_SLAVE_MISO_EN
  localparam logic [15:0] EXP_MISO_WORD = 16'hBEEF;
`else
  localparam logic [15:0] EXP_MISO_WORD = 16'h0000;
`endif

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } exp_t;

  logic               clk;
  logic               reset_n;
  logic               sclk;
  logic               cs;
  logic               mosi;
  logic               miso;
  logic [D_WIDTH-1:0] tx_data;
  logic [D_WIDTH-1:0] d_out;
  logic               d_valid;
  logic               frame_err;
  logic               busy;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_fail;
  logic [15:0] mw;

  spi_slave_rx #(.D_WIDTH(D_WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .d_out(d_out), .d_valid(d_valid),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_err, input logic [15:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && (d_valid || frame_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: d_valid=%0b frame_err=%0b d_out=%h, expected no pulse",
                 d_valid, frame_err, d_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (d_valid !== !mon_e.is_err || frame_err !== mon_e.is_err || d_out !== mon_e.data) begin
          n_fail++;
          $display("FAIL scoreboard: d_valid=%0b frame_err=%0b d_out=%h, expected d_valid=%0b frame_err=%0b d_out=%h",
                   d_valid, frame_err, d_out, !mon_e.is_err, mon_e.is_err, mon_e.data);
        end
      end
    end
  end

  task automatic send_bits(input logic [31:0] bits, input int nbits, input int half,
                           input bit cs_on_last, output logic [15:0] mw_o);
    mw_o = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[nbits-1-i];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      if (cs_on_last && i == nbits - 1) cs = 1'b1;
      mw_o = {mw_o[14:0], miso};
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int nbits, input int half, input int gap,
                       input bit cs_on_last, output logic [15:0] mw_o);
    cs = 1'b0;
    @(negedge clk);
    send_bits(bits, nbits, half, cs_on_last, mw_o);
    repeat (half) @(negedge clk);
    cs = 1'b1;
    if (gap >= 4) begin
      repeat (4) @(negedge clk);
      check("busy_after_cs_rise", {31'd0, busy}, 32'd0);
      repeat (gap - 4) @(negedge clk);
    end else begin
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    sclk     = 1'b0;
    cs       = 1'b1;
    mosi     = 1'b0;
    tx_data  = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_d_out",     {16'd0, d_out},     32'd0);
    check("rst_d_valid",   {31'd0, d_valid},   32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_miso",      {31'd0, miso},      32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: plain frame
    push(1'b0, 16'hA5C3);
    frame({16'd0, 16'hA5C3}, 16, 2, 6, 1'b0, mw);
    drain("t1_drain");

    // 2: short frame of 9 ones, d_out must keep the previous word
    push(1'b1, 16'hA5C3);
    frame({23'd0, 9'h1FF}, 9, 2, 6, 1'b0, mw);
    drain("t2_drain");
    check("t2_d_out_kept", {16'd0, d_out}, {16'd0, 16'hA5C3});

    // 3: 17 sclk pulses -> word then one error
    push(1'b0, 16'h8001);
    push(1'b1, 16'h8001);
    frame({15'd0, 16'h8001, 1'b1}, 17, 2, 6, 1'b0, mw);
    drain("t3_drain");

    // 4: reset mid-frame with cs held low, then a clean frame
    cs = 1'b0;
    @(negedge clk);
    send_bits({24'd0, 8'hC3}, 8, 2, 1'b0, mw);
    reset_n = 1'b0;
    @(negedge clk);
    check("t4_rst_d_out", {16'd0, d_out}, 32'd0);
    check("t4_rst_busy",  {31'd0, busy},  32'd0);
    reset_n = 1'b1;
    send_bits({24'd0, 8'h5A}, 8, 2, 1'b0, mw);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    drain("t4_no_pulse");
    push(1'b0, 16'h1234);
    frame({16'd0, 16'h1234}, 16, 2, 6, 1'b0, mw);
    drain("t4_drain");

    // 5: back-to-back frames, cs high 3 clk between them
    push(1'b0, 16'h0001);
    push(1'b0, 16'h8000);
    frame({16'd0, 16'h0001}, 16, 2, 3, 1'b0, mw);
    frame({16'd0, 16'h8000}, 16, 2, 6, 1'b0, mw);
    drain("t5_drain");

    // 6: sclk = clk/8 with a transmit word
    tx_data = 16'hBEEF;
    push(1'b0, 16'h0F0F);
    frame({16'd0, 16'h0F0F}, 16, 4, 8, 1'b0, mw);
    drain("t6_drain");
    check("t6_miso_word", {16'd0, mw}, {16'd0, EXP_MISO_WORD});

    // 7: cs rises together with the final sclk rise -> accepted, no error
    push(1'b0, 16'h5AA5);
    frame({16'd0, 16'h5AA5}, 16, 2, 6, 1'b1, mw);
    drain("t7_drain");

    // 8: 18 pulses -> word then only one error for the frame
    push(1'b0, 16'h00FF);
    push(1'b1, 16'h00FF);
    frame({14'd0, 16'h00FF, 2'b11}, 18, 2, 6, 1'b0, mw);
    drain("t8_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
